// File: rtl/registrador_bloqueante_4b.sv
`default_nettype none
// +------------------------------------------------------------------+
// | registrador_bloqueante_4b                                         |
// | 4-stage serial-in / parallel-out shift register (A newest, D old) |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module registrador_bloqueante_4b #(
  parameter logic [3:0] RESET_VALUE = 4'b0000
) (
  input  logic clock,
  input  logic reset,
  input  logic entrada,
  output logic A,
  output logic B,
  output logic C,
  output logic D
);

  // Bit 3 is stage A, bit 0 is stage D.
  logic [3:0] r_stages;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stages <= RESET_VALUE;
    end else begin
      r_stages <= {entrada, r_stages[3:1]};
    end
  end

  assign A = r_stages[3];
  assign B = r_stages[2];
  assign C = r_stages[1];
  assign D = r_stages[0];

endmodule
`default_nettype wire

// File: tb/tb_registrador_bloqueante_4b.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_registrador_bloqueante_4b                                      |
// | Scoreboard bench for the 4-stage shift register                   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_registrador_bloqueante_4b;

  logic clock;
  logic reset;
  logic entrada;
  logic A, B, C, D;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] exp_q[$];
  string      tag_q[$];
  logic [3:0] r_model;

  registrador_bloqueante_4b #(.RESET_VALUE(4'b0000)) dut (
    .clock  (clock),
    .reset  (reset),
    .entrada(entrada),
    .A      (A),
    .B      (B),
    .C      (C),
    .D      (D)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got ABCD=%b expected ABCD=%b", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and queue what ABCD must be after the next rising edge.
  task automatic drive(input string tag, input logic r, input logic d, input logic [3:0] exp);
    @(negedge clock);
    reset   = r;
    entrada = d;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    r_model = exp;
  endtask

  always @(posedge clock) begin
    #1;
    if (exp_q.size() != 0) begin
      check_eq(tag_q.pop_front(), {A, B, C, D}, exp_q.pop_front());
    end
  end

  initial begin
    logic       r;
    logic       d;
    logic [3:0] nxt;
    reset   = 1'b0;
    entrada = 1'b0;
    r_model = 4'b0000;

    drive("reset", 1'b1, 1'b0, 4'b0000);

    drive("walk_in_nocollapse", 1'b0, 1'b1, 4'b1000);
    drive("walk_b", 1'b0, 1'b0, 4'b0100);
    drive("walk_c", 1'b0, 1'b0, 4'b0010);
    drive("walk_d", 1'b0, 1'b0, 4'b0001);
    drive("walk_out", 1'b0, 1'b0, 4'b0000);

    drive("fill1", 1'b0, 1'b1, 4'b1000);
    drive("fill2", 1'b0, 1'b1, 4'b1100);
    drive("fill3", 1'b0, 1'b1, 4'b1110);
    drive("fill4", 1'b0, 1'b1, 4'b1111);
    drive("drain1", 1'b0, 1'b0, 4'b0111);
    drive("drain2", 1'b0, 1'b0, 4'b0011);
    drive("drain3", 1'b0, 1'b0, 4'b0001);
    drive("drain4", 1'b0, 1'b0, 4'b0000);

    drive("pat_reset", 1'b1, 1'b1, 4'b0000);
    drive("pat1", 1'b0, 1'b1, 4'b1000);
    drive("pat2", 1'b0, 1'b0, 4'b0100);
    drive("pat3", 1'b0, 1'b1, 4'b1010);
    drive("pat4", 1'b0, 1'b1, 4'b1101);

    drive("refill1", 1'b0, 1'b1, 4'b1110);
    drive("refill2", 1'b0, 1'b1, 4'b1111);
    drive("reset_priority", 1'b1, 1'b1, 4'b0000);
    drive("after_reset", 1'b0, 1'b1, 4'b1000);

    // Random traffic against an independent reference of the shift.
    for (int i = 0; i < 40; i++) begin
      r   = ($urandom_range(0, 9) == 0);
      d   = 1'($urandom_range(0, 1));
      nxt = r ? 4'b0000 : {d, r_model[3:1]};
      drive("random", r, d, nxt);
    end

    repeat (3) @(negedge clock);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_queue: got %0d pending expected 0 pending", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
